debounce_multi_hold: RTL and testbench

//   N-channel button conditioner; successor to the single-channel debouncer.
//   Per channel: 2-flop sync, selectable polarity, counter debounce, press/release edge pulses, long-press detect, auto-repeat.

---
 rtl/debounce_pkg.sv | 33 +++
 rtl/debounce_channel.sv | 177 +++++++++++++++++
 rtl/debounce_multi_hold.sv | 54 +++++
 tb/tb_debounce_multi_hold.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the multi-channel button conditioner.
//   - hold_state_t : per-channel hold FSM encoding (IDLE / HOLD / LONG)
//   - max3         : largest of three cycle counts
//   - cnt_width    : counter width able to hold values up to max_cyc-1,
//                    never narrower than one bit
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // The counters only ever hold values in 0..max_cyc-1, so $clog2 of the
    // largest count is enough; clamping to 2 keeps the width at least 1.
    function automatic int cnt_width(input int max_cyc);
        int m;
        m = (max_cyc < 2) ? 2 : max_cyc;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: 2-flop synchroniser with polarity correction,
//   counter-based debounce, press/release edge pulses and a hold FSM that
//   produces a single long-press pulse followed by periodic repeat pulses.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   btn_in         in   raw asynchronous button pin
//   btn_level      out  debounced level, 1 = pressed
//   press_pulse    out  1-cycle pulse in the first cycle btn_level is 1
//   release_pulse  out  1-cycle pulse in the first cycle btn_level is 0
//   long_pulse     out  1-cycle pulse after LONG_CYC held cycles, once per press
//   repeat_pulse   out  1-cycle pulse every RPT_CYC cycles while in LONG
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DB_CYC     = 1_000_000,
    parameter int LONG_CYC   = 50_000_000,
    parameter int RPT_CYC    = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W = cnt_width(max3(DB_CYC, LONG_CYC, RPT_CYC));
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'((RPT_CYC > 0) ? (RPT_CYC - 1) : 0);
    localparam bit               RPT_ON    = (RPT_CYC > 0);

    logic              pin_pressed;
    logic              sync_q1;
    logic              sync_q2;
    logic              level_q;
    logic [CNT_W-1:0]  db_cnt_q;
    logic              press_q;
    logic              release_q;
    logic              mismatch;
    logic              accept;
    logic              press_evt;
    logic              release_evt;

    hold_state_t       state_q;
    hold_state_t       state_d;
    logic [CNT_W-1:0]  hold_cnt_q;
    logic [CNT_W-1:0]  hold_cnt_d;
    logic              long_q;
    logic              long_d;
    logic              repeat_q;
    logic              repeat_d;

    // Polarity is folded in ahead of the first flop so everything downstream
    // works in "1 = pressed" terms and reset can load the released value 0.
    assign pin_pressed = ACTIVE_LOW ? ~btn_in : btn_in;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pin_pressed;
            sync_q2 <= sync_q1;
        end
    end

    // A change is accepted only after DB_CYC consecutive mismatching cycles;
    // the event signals are shared with the hold FSM so that it moves in the
    // same edge as btn_level.
    assign mismatch    = (sync_q2 != level_q);
    assign accept      = mismatch && (db_cnt_q == DB_LAST);
    assign press_evt   = accept &&  sync_q2;
    assign release_evt = accept && !sync_q2;

    // Debounce counter, debounced level and the registered edge pulses.
    // Any matching cycle clears the counter, discarding short glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= press_evt;
            release_q <= release_evt;
            if (accept) begin
                level_q  <= sync_q2;
                db_cnt_q <= '0;
            end else if (mismatch) begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Hold FSM state, hold counter and registered long/repeat pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    // Next-state logic. A release wins over everything, which is what keeps
    // long/repeat pulses out of the release cycle. Leaving LONG only happens
    // on release, so long_pulse can fire at most once per press.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        if (release_evt) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    hold_cnt_d = '0;
                    if (press_evt) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == LONG_LAST) begin
                        long_d     = 1'b1;
                        state_d    = LONG;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                LONG: begin
                    if (RPT_ON) begin
                        if (hold_cnt_q == RPT_LAST) begin
                            repeat_d   = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end else begin
                        hold_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/debounce_multi_hold.sv
// -----------------------------------------------------------------------------
// debounce_multi_hold
//   N-channel button conditioner. Each bit of btn_in is handled by its own,
//   fully independent debounce_channel; outputs are bit-aligned with btn_in.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   btn_in         in   [N_CH] raw asynchronous button pins
//   btn_level      out  [N_CH] debounced level, 1 = pressed
//   press_pulse    out  [N_CH] 1-cycle pulse on debounced press
//   release_pulse  out  [N_CH] 1-cycle pulse on debounced release
//   long_pulse     out  [N_CH] 1-cycle pulse once per press after LONG_CYC
//   repeat_pulse   out  [N_CH] 1-cycle pulse every RPT_CYC cycles in LONG
// -----------------------------------------------------------------------------
module debounce_multi_hold
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DB_CYC     = 1_000_000,
    parameter int LONG_CYC   = 50_000_000,
    parameter int RPT_CYC    = 10_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    // One channel per button; no state is shared between channels.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .DB_CYC     (DB_CYC),
            .LONG_CYC   (LONG_CYC),
            .RPT_CYC    (RPT_CYC)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .btn_in        (btn_in[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi_hold.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi_hold
//   Two DUT copies (N_CH=2, active-low, DB_CYC=8, LONG_CYC=40): dut_a with
//   RPT_CYC=10 and dut_b with repeat disabled. Stimulus pushes expected pulse
//   events (cycle + pulse vectors) into per-DUT queues; a negedge monitor pops
//   one entry whenever a DUT shows any pulse. Levels are also spot-checked.
// -----------------------------------------------------------------------------
module tb_debounce_multi_hold;

    typedef struct packed {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lg;
        logic [1:0] rp;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_a;
    logic [1:0] btn_b;
    logic [1:0] level_a, press_a, release_a, long_a, rpt_a;
    logic [1:0] level_b, press_b, release_b, long_b, rpt_b;

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    int  c0;
    ev_t q_a[$];
    ev_t q_b[$];

    always #5 clk = ~clk;

    // Cycle number = count of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    debounce_multi_hold #(
        .N_CH(2), .ACTIVE_LOW(1'b1), .DB_CYC(8), .LONG_CYC(40), .RPT_CYC(10)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_a),
        .btn_level(level_a), .press_pulse(press_a), .release_pulse(release_a),
        .long_pulse(long_a), .repeat_pulse(rpt_a)
    );

    debounce_multi_hold #(
        .N_CH(2), .ACTIVE_LOW(1'b1), .DB_CYC(8), .LONG_CYC(40), .RPT_CYC(0)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_b),
        .btn_level(level_b), .press_pulse(press_b), .release_pulse(release_b),
        .long_pulse(long_b), .repeat_pulse(rpt_b)
    );

    task automatic push_expect(input bit to_b, input int at, input logic [1:0] pr,
                               input logic [1:0] rl, input logic [1:0] lg, input logic [1:0] rp);
        ev_t e;
        e.cyc = at;
        e.pr  = pr;
        e.rl  = rl;
        e.lg  = lg;
        e.rp  = rp;
        if (to_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    task automatic compare_ev(input string tag, input bit have, input ev_t exp,
                              input logic [1:0] pr, input logic [1:0] rl,
                              input logic [1:0] lg, input logic [1:0] rp);
        total++;
        if (!have) begin
            bad++;
            $display("[TB] FAIL %s unexpected pulse cyc=%0d pr=%b rl=%b lg=%b rp=%b, required none",
                     tag, cyc, pr, rl, lg, rp);
        end else if (exp.cyc != cyc || {pr, rl, lg, rp} !== {exp.pr, exp.rl, exp.lg, exp.rp}) begin
            bad++;
            $display("[TB] FAIL %s got cyc=%0d pr=%b rl=%b lg=%b rp=%b, required cyc=%0d pr=%b rl=%b lg=%b rp=%b",
                     tag, cyc, pr, rl, lg, rp, exp.cyc, exp.pr, exp.rl, exp.lg, exp.rp);
        end
    endtask

    // Scoreboard monitor: any pulse on a DUT consumes its next expected event.
    always @(negedge clk) begin
        ev_t e;
        bit  have;
        if ((|{press_a, release_a, long_a, rpt_a}) === 1'b1) begin
            have = (q_a.size() != 0);
            e    = '0;
            if (have) e = q_a.pop_front();
            compare_ev("event_a", have, e, press_a, release_a, long_a, rpt_a);
        end
        if ((|{press_b, release_b, long_b, rpt_b}) === 1'b1) begin
            have = (q_b.size() != 0);
            e    = '0;
            if (have) e = q_b.pop_front();
            compare_ev("event_b", have, e, press_b, release_b, long_b, rpt_b);
        end
    end

    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b);
        btn_a = a;
        btn_b = b;
    endtask

    // exp = {level, press, release, long, repeat}
    task automatic checkOutput(input string name, input bit on_b, input logic [9:0] exp);
        logic [9:0] act;
        act = on_b ? {level_b, press_b, release_b, long_b, rpt_b}
                   : {level_a, press_a, release_a, long_a, rpt_a};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got %b required %b", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog cyc=%0d got timeout required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(2'b00, 2'b11);

        // 1. Reset with both buttons pressed; press appears 10 cycles after rst falls
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("reset_quiet_a", 1'b0, 10'b0);
            checkOutput("reset_quiet_b", 1'b1, 10'b0);
        end
        c0  = cyc;
        rst = 1'b0;
        push_expect(0, c0 + 10, 2'b11, 2'b00, 2'b00, 2'b00);
        goto(c0 + 9);  checkOutput("t1_before_press", 1'b0, 10'b0);
        goto(c0 + 10); checkOutput("t1_press", 1'b0, {2'b11, 2'b11, 6'b0});
        goto(c0 + 12); applyStimulus(2'b11, 2'b11);
        push_expect(0, c0 + 22, 2'b00, 2'b11, 2'b00, 2'b00);
        goto(c0 + 21); checkOutput("t1_held", 1'b0, {2'b11, 8'b0});
        goto(c0 + 22); checkOutput("t1_release", 1'b0, {2'b00, 2'b00, 2'b11, 4'b0});

        // 2. Clean press on ch0 only
        goto(c0 + 30);
        c0 = cyc;
        applyStimulus(2'b10, 2'b11);
        push_expect(0, c0 + 10, 2'b01, 2'b00, 2'b00, 2'b00);
        goto(c0 + 9);  checkOutput("t2_before_press", 1'b0, 10'b0);
        goto(c0 + 10); checkOutput("t2_press", 1'b0, {2'b01, 2'b01, 6'b0});
        goto(c0 + 11); checkOutput("t2_level_hold", 1'b0, {2'b01, 8'b0});
        goto(c0 + 15); applyStimulus(2'b11, 2'b11);
        push_expect(0, c0 + 25, 2'b00, 2'b01, 2'b00, 2'b00);
        goto(c0 + 25); checkOutput("t2_release", 1'b0, {2'b00, 2'b00, 2'b01, 4'b0});

        // 3. Bounce: 5 low / 2 high, four times, never accepted
        goto(c0 + 35);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b10, 2'b11);
            goto(cyc + 5);
            checkOutput("t3_bounce_low", 1'b0, 10'b0);
            applyStimulus(2'b11, 2'b11);
            goto(cyc + 2);
        end
        goto(cyc + 20);
        checkOutput("t3_bounce_after", 1'b0, 10'b0);

        // 4. Long press with repeats on ch0, released after 100 held cycles
        c0 = cyc;
        applyStimulus(2'b10, 2'b11);
        push_expect(0, c0 + 10, 2'b01, 2'b00, 2'b00, 2'b00);
        push_expect(0, c0 + 50, 2'b00, 2'b00, 2'b01, 2'b00);
        for (int k = 60; k <= 110; k += 10)
            push_expect(0, c0 + k, 2'b00, 2'b00, 2'b00, 2'b01);
        push_expect(0, c0 + 120, 2'b00, 2'b01, 2'b00, 2'b00);
        goto(c0 + 49);  checkOutput("t4_before_long", 1'b0, {2'b01, 8'b0});
        goto(c0 + 50);  checkOutput("t4_long", 1'b0, {2'b01, 2'b00, 2'b00, 2'b01, 2'b00});
        goto(c0 + 60);  checkOutput("t4_first_repeat", 1'b0, {2'b01, 2'b00, 2'b00, 2'b00, 2'b01});
        goto(c0 + 110); checkOutput("t4_last_repeat", 1'b0, {2'b01, 2'b00, 2'b00, 2'b00, 2'b01});
        applyStimulus(2'b11, 2'b11);
        goto(c0 + 120); checkOutput("t4_release", 1'b0, {2'b00, 2'b00, 2'b01, 4'b0});
        goto(c0 + 140); checkOutput("t4_quiet", 1'b0, 10'b0);

        // 5. Simultaneous press, reset mid-LONG, still held -> fresh press
        c0 = cyc;
        applyStimulus(2'b00, 2'b11);
        push_expect(0, c0 + 10, 2'b11, 2'b00, 2'b00, 2'b00);
        push_expect(0, c0 + 50, 2'b00, 2'b00, 2'b11, 2'b00);
        push_expect(0, c0 + 60, 2'b00, 2'b00, 2'b00, 2'b11);
        push_expect(0, c0 + 77, 2'b11, 2'b00, 2'b00, 2'b00);
        push_expect(0, c0 + 90, 2'b00, 2'b11, 2'b00, 2'b00);
        goto(c0 + 10); checkOutput("t5_both_press", 1'b0, {2'b11, 2'b11, 6'b0});
        goto(c0 + 60); checkOutput("t5_both_repeat", 1'b0, {2'b11, 2'b00, 2'b00, 2'b00, 2'b11});
        goto(c0 + 65); rst = 1'b1;
        goto(c0 + 66); checkOutput("t5_reset_clear", 1'b0, 10'b0);
        goto(c0 + 67); checkOutput("t5_reset_hold", 1'b0, 10'b0);
        rst = 1'b0;
        goto(c0 + 76); checkOutput("t5_before_repress", 1'b0, 10'b0);
        goto(c0 + 77); checkOutput("t5_repress", 1'b0, {2'b11, 2'b11, 6'b0});
        goto(c0 + 80); applyStimulus(2'b11, 2'b11);
        goto(c0 + 90); checkOutput("t5_release", 1'b0, {2'b00, 2'b00, 2'b11, 4'b0});
        goto(c0 + 100);

        // 6. Repeat disabled: 200-cycle hold on dut_b ch1
        c0 = cyc;
        applyStimulus(2'b11, 2'b01);
        push_expect(1, c0 + 10, 2'b10, 2'b00, 2'b00, 2'b00);
        push_expect(1, c0 + 50, 2'b00, 2'b00, 2'b10, 2'b00);
        push_expect(1, c0 + 220, 2'b00, 2'b10, 2'b00, 2'b00);
        goto(c0 + 50);  checkOutput("t6_long", 1'b1, {2'b10, 2'b00, 2'b00, 2'b10, 2'b00});
        goto(c0 + 150); checkOutput("t6_no_repeat", 1'b1, {2'b10, 8'b0});
        goto(c0 + 210); applyStimulus(2'b11, 2'b11);
        goto(c0 + 220); checkOutput("t6_release", 1'b1, {2'b00, 2'b00, 2'b10, 4'b0});
        goto(c0 + 240); checkOutput("t6_quiet_a", 1'b0, 10'b0);

        // Every expected event must have been consumed.
        total++;
        if (q_a.size() != 0) begin
            bad++;
            $display("[TB] FAIL leftover_a got %0d pending events required 0", q_a.size());
        end
        total++;
        if (q_b.size() != 0) begin
            bad++;
            $display("[TB] FAIL leftover_b got %0d pending events required 0", q_b.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
